sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO for SoC-side buffering of byte, word and parity-carrying streams.
- Replaces fixed-geometry primitive FIFOs with an inferred-RAM block of any width and power-of-two depth.
- Provides selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count and read/write error pulses.
- Sits between UART/SD/Ethernet datapaths and the AXI-facing logic, where both sides share one clock.

---
 rtl/sync_fifo_param.sv | 134 +++++++++++++
 tb/tb_sync_fifo_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO over an inferred simple dual-port RAM.
// Standard (1-cycle read latency) or first-word-fall-through read mode,
// registered occupancy count, threshold flags and read/write error pulses.
module sync_fifo_param #(
    parameter int unsigned width               = 36,
    parameter int unsigned depth_log2          = 9,
    parameter int unsigned fwft                = 0,
    parameter int unsigned almost_full_offset  = 128,
    parameter int unsigned almost_empty_offset = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [width-1:0]      din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [width-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [depth_log2:0]   count,
    output logic                  rderr,
    output logic                  wrerr
);

    localparam int unsigned           DEPTH    = 2 ** depth_log2;
    localparam int unsigned           CW       = depth_log2 + 1;
    localparam bit                    FWFT     = (fwft != 0);
    localparam logic [depth_log2:0]   L_DEPTH  = CW'(DEPTH);
    localparam logic [depth_log2:0]   L_AF_LVL = CW'(DEPTH - almost_full_offset);
    localparam logic [depth_log2:0]   L_AE_LVL = CW'(almost_empty_offset);

    logic [width-1:0]        r_mem [DEPTH];
    logic [depth_log2-1:0]   r_wr_ptr;
    logic [depth_log2-1:0]   r_rd_ptr;
    logic [depth_log2:0]     r_count;
    logic [depth_log2:0]     r_ram_cnt;
    logic                    r_out_vld;
    logic [width-1:0]        r_dout;
    logic                    r_full;
    logic                    r_empty;
    logic                    r_af;
    logic                    r_ae;
    logic                    r_rderr;
    logic                    r_wrerr;

    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic                    w_pop;
    logic                    w_out_vld_nx;
    logic                    w_empty_nx;
    logic [depth_log2:0]     w_count_nx;
    logic [depth_log2:0]     w_ram_cnt_nx;

    // Acceptance from pre-edge flags, next-state occupancy and RAM pop control.
    // In FWFT mode the RAM feeds a one-word output stage: count covers RAM
    // plus that stage, and empty reflects only the output stage.
    always_comb begin
        w_wr_acc = wr_en & ~r_full;
        w_rd_acc = rd_en & ~r_empty;

        w_count_nx = r_count;
        if (w_wr_acc && !w_rd_acc)
            w_count_nx = r_count + 1'b1;
        else if (!w_wr_acc && w_rd_acc)
            w_count_nx = r_count - 1'b1;

        if (FWFT) begin
            w_pop        = (r_ram_cnt != '0) && (!r_out_vld || w_rd_acc);
            w_out_vld_nx = w_pop | (r_out_vld & ~w_rd_acc);
        end else begin
            w_pop        = w_rd_acc;
            w_out_vld_nx = 1'b0;
        end

        w_ram_cnt_nx = r_ram_cnt;
        if (w_wr_acc && !w_pop)
            w_ram_cnt_nx = r_ram_cnt + 1'b1;
        else if (!w_wr_acc && w_pop)
            w_ram_cnt_nx = r_ram_cnt - 1'b1;

        w_empty_nx = FWFT ? ~w_out_vld_nx : (w_count_nx == '0);
    end

    // Storage array write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst)
            r_mem[r_wr_ptr] <= din;
    end

    // Pointers, registered read data, flags, count and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ram_cnt <= '0;
            r_out_vld <= 1'b0;
            r_dout    <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_af      <= 1'b0;
            r_ae      <= 1'b1;
            r_rderr   <= 1'b0;
            r_wrerr   <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count   <= w_count_nx;
            r_ram_cnt <= w_ram_cnt_nx;
            r_out_vld <= w_out_vld_nx;
            r_full    <= (w_count_nx == L_DEPTH);
            r_empty   <= w_empty_nx;
            r_af      <= (w_count_nx >= L_AF_LVL);
            r_ae      <= (w_count_nx <= L_AE_LVL);
            r_rderr   <= rd_en & r_empty;
            r_wrerr   <= wr_en & r_full;
        end
    end

    assign dout        = r_dout;
    assign full        = r_full;
    assign empty       = r_empty;
    assign almostfull  = r_af;
    assign almostempty = r_ae;
    assign count       = r_count;
    assign rderr       = r_rderr;
    assign wrerr       = r_wrerr;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: a table of directed vectors on a 16-deep
// standard-mode instance, plus hand-written sequences on a FWFT instance.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-mode instance signals
    logic        a_rst = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
    logic [35:0] a_din = '0, a_dout;
    logic        a_full, a_empty, a_af, a_ae, a_rderr, a_wrerr;
    logic [4:0]  a_count;

    // FWFT instance signals
    logic        f_rst = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
    logic [35:0] f_din = '0, f_dout;
    logic        f_full, f_empty, f_af, f_ae, f_rderr, f_wrerr;
    logic [4:0]  f_count;

    sync_fifo_param #(
        .width(36), .depth_log2(4), .fwft(0),
        .almost_full_offset(3), .almost_empty_offset(2)
    ) u_std (
        .clk(clk), .rst(a_rst), .din(a_din), .wr_en(a_wr), .rd_en(a_rd),
        .dout(a_dout), .full(a_full), .empty(a_empty), .almostfull(a_af),
        .almostempty(a_ae), .count(a_count), .rderr(a_rderr), .wrerr(a_wrerr)
    );

    sync_fifo_param #(
        .width(36), .depth_log2(4), .fwft(1),
        .almost_full_offset(3), .almost_empty_offset(2)
    ) u_fwft (
        .clk(clk), .rst(f_rst), .din(f_din), .wr_en(f_wr), .rd_en(f_rd),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almostfull(f_af),
        .almostempty(f_ae), .count(f_count), .rderr(f_rderr), .wrerr(f_wrerr)
    );

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rd;
        logic [35:0] din;
        logic [35:0] dout;
        int          cnt;
        logic        rderr;
        logic        wrerr;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void add(input logic r, input logic w, input logic rd,
                                input logic [35:0] din, input logic [35:0] dout,
                                input int cnt, input logic re, input logic we);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rd; v.din = din; v.dout = dout;
        v.cnt = cnt; v.rderr = re; v.wrerr = we;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] wd(input logic [35:0] base, input int i);
        return base + 36'(i);
    endfunction

    localparam logic [35:0] B1 = 36'h1_0000_0000;
    localparam logic [35:0] BW = 36'h2_0000_0000;
    localparam logic [35:0] BM = 36'h3_0000_0000;
    localparam logic [35:0] N1 = 36'h4_1234_5678;
    localparam logic [35:0] X1 = 36'h5_5555_5555;

    initial begin
        logic [35:0] last;
        int          edges;

        // ---------------- vector table (standard mode) ----------------
        add(1, 1, 1, 36'h7, '0, 0, 0, 0);                     // reset ignores requests
        for (int k = 1; k <= 16; k++)
            add(0, 1, 0, wd(B1, k), '0, k, 0, 0);             // fill, thresholds
        add(0, 1, 0, 36'hD_EAD0, '0, 16, 0, 1);               // overflow
        add(0, 0, 0, '0, '0, 16, 0, 0);                       // wrerr one cycle only
        add(0, 1, 1, 36'hD_EAD1, wd(B1, 1), 15, 0, 1);        // simultaneous at full
        for (int k = 2; k <= 16; k++)
            add(0, 0, 1, '0, wd(B1, k), 16 - k, 0, 0);        // drain in order
        last = wd(B1, 16);
        add(0, 0, 1, '0, last, 0, 1, 0);                      // underflow
        add(0, 1, 1, X1, last, 1, 1, 0);                      // simultaneous at empty
        add(0, 0, 0, '0, last, 1, 0, 0);
        add(0, 0, 1, '0, X1, 0, 0, 0);
        for (int i = 1; i <= 7; i++)
            add(0, 1, 0, wd(BW, i), X1, i, 0, 0);             // build count=7
        for (int i = 8; i <= 17; i++)
            add(0, 1, 1, wd(BW, i), wd(BW, i - 7), 7, 0, 0);  // steady, pointer wrap
        for (int i = 11; i <= 17; i++)
            add(0, 0, 1, '0, wd(BW, i), 17 - i, 0, 0);
        for (int i = 1; i <= 9; i++)
            add(0, 1, 0, wd(BM, i), wd(BW, 17), i, 0, 0);     // count=9
        add(1, 1, 1, N1, '0, 0, 0, 0);                        // mid-stream reset
        add(0, 1, 0, N1, '0, 1, 0, 0);
        add(0, 0, 1, '0, N1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            a_rst = vecs[i].rst;
            a_wr  = vecs[i].wr;
            a_rd  = vecs[i].rd;
            a_din = vecs[i].din;
            tick();
            chk($sformatf("v%0d dout", i),  a_dout,  vecs[i].dout);
            chk($sformatf("v%0d count", i), a_count, 64'(vecs[i].cnt));
            chk($sformatf("v%0d full", i),  a_full,  vecs[i].cnt == 16);
            chk($sformatf("v%0d empty", i), a_empty, vecs[i].cnt == 0);
            chk($sformatf("v%0d almostfull", i),  a_af, vecs[i].cnt >= 13);
            chk($sformatf("v%0d almostempty", i), a_ae, vecs[i].cnt <= 2);
            chk($sformatf("v%0d rderr", i), a_rderr, vecs[i].rderr);
            chk($sformatf("v%0d wrerr", i), a_wrerr, vecs[i].wrerr);
        end
        a_rst = 0; a_wr = 0; a_rd = 0;

        // ---------------- FWFT sequences ----------------
        f_rst = 1; tick(); f_rst = 0;
        chk("fwft rst empty", f_empty, 1);
        chk("fwft rst count", f_count, 0);

        f_wr = 1; f_din = 36'hA5; tick(); f_wr = 0;
        chk("fwft wr count", f_count, 1);
        edges = 1;
        while (f_empty && edges < 2) begin
            tick();
            edges++;
        end
        chk("fwft fall-through empty", f_empty, 0);
        chk("fwft fall-through dout", f_dout, 36'hA5);

        f_rd = 1; tick(); f_rd = 0;
        chk("fwft rd empty", f_empty, 1);
        chk("fwft rd count", f_count, 0);
        chk("fwft rd rderr", f_rderr, 0);

        f_rd = 1; tick(); f_rd = 0;
        chk("fwft underflow rderr", f_rderr, 1);
        chk("fwft underflow count", f_count, 0);

        for (int j = 1; j <= 3; j++) begin
            f_wr = 1; f_din = wd(36'h6_0000_0000, j); tick();
        end
        f_wr = 0;
        tick(); tick();
        for (int j = 1; j <= 3; j++) begin
            chk($sformatf("fwft seq%0d dout", j),  f_dout, wd(36'h6_0000_0000, j));
            chk($sformatf("fwft seq%0d count", j), f_count, 64'(4 - j));
            chk($sformatf("fwft seq%0d empty", j), f_empty, 0);
            f_rd = 1; tick(); f_rd = 0;
        end
        chk("fwft drained empty", f_empty, 1);
        chk("fwft drained count", f_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
